// File: rtl/usb2_ep2_out_if.sv
// Endpoint 2 bulk OUT signal bundle: protocol-layer side plus user read side.
// The master drives tokens, payload writes and user reads; the slave is the endpoint.
interface usb2_ep2_out_if #(
    parameter int ADDR_W = 9
);
    logic              xfer_out;
    logic              xfer_out_ok;
    logic [3:0]        xfer_pid;
    logic [9:0]        xfer_out_len;
    logic              xfer_ready;
    logic [ADDR_W-1:0] buf_in_addr;
    logic [7:0]        buf_in_data;
    logic              buf_in_wren;
    logic              clear_toggle;
    logic [ADDR_W-1:0] usr_rd_addr;
    logic [7:0]        usr_rd_q;
    logic              usr_pkt_valid;
    logic [9:0]        usr_pkt_len;
    logic              usr_pkt_done;
    logic              dbg;

    modport master (
        output xfer_out, xfer_out_ok, xfer_pid, xfer_out_len,
        output buf_in_addr, buf_in_data, buf_in_wren, clear_toggle,
        output usr_rd_addr, usr_pkt_done,
        input  xfer_ready, usr_rd_q, usr_pkt_valid, usr_pkt_len, dbg
    );

    modport slave (
        input  xfer_out, xfer_out_ok, xfer_pid, xfer_out_len,
        input  buf_in_addr, buf_in_data, buf_in_wren, clear_toggle,
        input  usr_rd_addr, usr_pkt_done,
        output xfer_ready, usr_rd_q, usr_pkt_valid, usr_pkt_len, dbg
    );
endinterface

// File: rtl/usb2_ep2_out.sv
// USB 2.0 bulk OUT endpoint 2: ping-pong 2-bank payload RAM, DATA0/DATA1 toggle
// tracking, ACK/NAK readiness and a valid/done packet hand-off to user logic.
module usb2_ep2_out #(
    parameter int MAX_PKT = 512,
    parameter int ADDR_W  = 9
) (
    input  logic          phy_clk,
    input  logic          reset,
    usb2_ep2_out_if.slave ep
);
    typedef enum logic [2:0] {
        ST_RST_0 = 3'd0,
        ST_RST_1 = 3'd1,
        ST_IDLE  = 3'd2,
        ST_RX    = 3'd3,
        ST_WAIT  = 3'd4,
        ST_NAK   = 3'd5
    } state_t;

    localparam logic [3:0] PID_DATA0 = 4'hC;
    localparam logic [3:0] PID_DATA1 = 4'h4;
    localparam logic [9:0] MAX_LEN   = 10'(MAX_PKT);
    localparam int         RAM_DEPTH = 2 << ADDR_W;

    function automatic logic [3:0] data_pid(input logic toggle);
        return toggle ? PID_DATA1 : PID_DATA0;
    endfunction

    state_t      state_r, state_nx_s;
    logic        xfer_out_r, xfer_ok_r;
    logic        out_rise_s, ok_rise_s;
    logic        accept_r, accept_nx_s;
    logic        commit_s, done_s, pkt_good_s;
    logic [1:0]  full_r, full_nx_s, set_s, clr_s;
    logic        wr_bank_r, wr_bank_nx_s;
    logic        rd_bank_r, rd_bank_nx_s;
    logic        exp_toggle_r, exp_toggle_nx_s;
    logic [9:0]  len_r [2];
    logic [9:0]  len_nx_s [2];
    logic        xfer_ready_r, pkt_valid_r;
    logic [9:0]  pkt_len_r;
    logic [7:0]  rd_q_r;
    logic [7:0]  ram_r [RAM_DEPTH];

    assign out_rise_s = ep.xfer_out & ~xfer_out_r;
    assign ok_rise_s  = ep.xfer_out_ok & ~xfer_ok_r;
    // A duplicate (opposite toggle) or foreign PID simply fails this test and is dropped.
    assign pkt_good_s = (ep.xfer_pid == data_pid(exp_toggle_r)) && (ep.xfer_out_len <= MAX_LEN);
    assign done_s     = ep.usr_pkt_done & full_r[rd_bank_r];

    assign set_s           = commit_s ? (wr_bank_r ? 2'b10 : 2'b01) : 2'b00;
    assign clr_s           = done_s ? (rd_bank_r ? 2'b10 : 2'b01) : 2'b00;
    assign full_nx_s       = (full_r | set_s) & ~clr_s;
    assign wr_bank_nx_s    = wr_bank_r ^ commit_s;
    assign rd_bank_nx_s    = rd_bank_r ^ done_s;
    assign exp_toggle_nx_s = ep.clear_toggle ? 1'b0 : (exp_toggle_r ^ commit_s);
    assign len_nx_s[0]     = set_s[0] ? ep.xfer_out_len : len_r[0];
    assign len_nx_s[1]     = set_s[1] ? ep.xfer_out_len : len_r[1];

    // FSM state register
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RST_0;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state, write-accept window and commit decision
    always_comb begin
        state_nx_s  = state_r;
        accept_nx_s = accept_r;
        commit_s    = 1'b0;
        case (state_r)
            ST_RST_0: begin
                state_nx_s  = ST_RST_1;
                accept_nx_s = 1'b0;
            end
            ST_RST_1: begin
                state_nx_s  = ST_IDLE;
                accept_nx_s = 1'b0;
            end
            ST_IDLE: begin
                if (out_rise_s && full_r[wr_bank_r]) begin
                    state_nx_s  = ST_NAK;
                    accept_nx_s = 1'b0;
                end else if (out_rise_s) begin
                    state_nx_s  = ST_RX;
                    accept_nx_s = 1'b1;
                end else begin
                    state_nx_s  = ST_IDLE;
                    accept_nx_s = 1'b0;
                end
            end
            ST_RX: begin
                if (ok_rise_s) begin
                    state_nx_s  = ST_WAIT;
                    accept_nx_s = 1'b0;
                    commit_s    = pkt_good_s;
                end else if (!ep.xfer_out) begin
                    state_nx_s  = ST_IDLE;
                    accept_nx_s = 1'b0;
                end else begin
                    state_nx_s  = ST_RX;
                    accept_nx_s = 1'b1;
                end
            end
            ST_WAIT, ST_NAK: begin
                state_nx_s  = ep.xfer_out ? state_r : ST_IDLE;
                accept_nx_s = 1'b0;
            end
            default: begin
                state_nx_s  = ST_IDLE;
                accept_nx_s = 1'b0;
            end
        endcase
    end

    // Edge-detect history, bank bookkeeping, toggle and registered outputs
    always_ff @(posedge phy_clk or posedge reset) begin
        if (reset) begin
            xfer_out_r   <= 1'b0;
            xfer_ok_r    <= 1'b0;
            accept_r     <= 1'b0;
            full_r       <= 2'b00;
            wr_bank_r    <= 1'b0;
            rd_bank_r    <= 1'b0;
            exp_toggle_r <= 1'b0;
            len_r[0]     <= 10'd0;
            len_r[1]     <= 10'd0;
            xfer_ready_r <= 1'b0;
            pkt_valid_r  <= 1'b0;
            pkt_len_r    <= 10'd0;
        end else begin
            xfer_out_r   <= ep.xfer_out;
            xfer_ok_r    <= ep.xfer_out_ok;
            accept_r     <= accept_nx_s;
            full_r       <= full_nx_s;
            wr_bank_r    <= wr_bank_nx_s;
            rd_bank_r    <= rd_bank_nx_s;
            exp_toggle_r <= exp_toggle_nx_s;
            len_r[0]     <= len_nx_s[0];
            len_r[1]     <= len_nx_s[1];
            // Held low through ST_RST_0 so it rises exactly as the FSM lands in ST_IDLE.
            xfer_ready_r <= (state_r == ST_RST_0) ? 1'b0 : ~full_r[wr_bank_r];
            pkt_valid_r  <= full_nx_s[rd_bank_nx_s];
            pkt_len_r    <= len_nx_s[rd_bank_nx_s];
        end
    end

    // Ping-pong payload RAM: bank bit is the address MSB; one-cycle read latency
    always_ff @(posedge phy_clk) begin
        if (ep.buf_in_wren && accept_r) begin
            ram_r[{wr_bank_r, ep.buf_in_addr}] <= ep.buf_in_data;
        end
        rd_q_r <= ram_r[{rd_bank_r, ep.usr_rd_addr}];
    end

    assign ep.xfer_ready    = xfer_ready_r;
    assign ep.usr_pkt_valid = pkt_valid_r;
    assign ep.usr_pkt_len   = pkt_len_r;
    assign ep.usr_rd_q      = rd_q_r;
    assign ep.dbg           = exp_toggle_r;
endmodule
